obi_xbar_n_to_one_ot: RTL and testbench
=======================================

// Module: obi_xbar_n_to_one_ot
// PURPOSE
// - N-master to 1-slave OBI arbiter for the system bus neck; successor to the single-outstanding N-to-1 stage.
// - Round-robin arbitration with request locking; up to MAX_OUTSTANDING accepted transactions in flight.
// - A route FIFO records the granted master index and steers in-order responses back to that master.
// - Data/address width and master count are parametrised.
// PARAMETERS
// - NMASTER          3   number of masters (>=1)
// - ADDR_WIDTH       32  OBI address width
// - DATA_WIDTH       32  OBI data width (multiple of 8); be width = DATA_WIDTH/8
// - MAX_OUTSTANDING  4   route FIFO depth (>=1); max accepted-but-unanswered transactions
// - obi_req_t        logic  struct {req, we, be, addr, wdata}
// - obi_resp_t       logic  struct {gnt, rvalid, rdata}
// PORTS
// - clk_i            in   1                          clock
// - rst_ni           in   1                          synchronous reset, active low
// - master_req_i     in   NMASTER x obi_req_t        master requests
// - master_resp_o    out  NMASTER x obi_resp_t       master responses
// - slave_req_o      out  obi_req_t                  request to neck slave
// - slave_resp_i     in   obi_resp_t                 response from neck slave
// - outstanding_o    out  $clog2(MAX_OUTSTANDING+1)  transactions in flight
// - rsp_err_o        out  1                          sticky: rvalid received with empty route FIFO
// - perf_gnt_cnt_o   out  NMASTER x 32               per-master accepted-request counters
// BEHAVIOUR
// - One clock clk_i; reset synchronous, active low (rst_ni sampled on clk_i edge).
// - Reset: rr pointer=0, lock=0, FIFO empty, outstanding_o=0, rsp_err_o=0, counters=0.
// - All outputs driven to 0 whenever the registered state is reset; no output is X after reset.
// - Request path combinational, 0-cycle latency: slave_req_o = master_req_i[sel] fields.
// - slave_req_o.req = master_req_i[sel].req & ~full; full = (outstanding_o == MAX_OUTSTANDING).
// - Full blocks grant even if a pop occurs in the same cycle (no push-on-pop bypass).
// - sel: when lock=0, first requesting master at or after rr pointer (wrapping NMASTER-1 -> 0).
// - Lock: slave_req_o.req=1 & slave gnt=0 -> lock_q=1, sel_q=sel; sel held until gnt (OBI stability).
// - Lock released on the cycle slave gnt=1 for the locked request.
// - master_resp_o[sel].gnt = slave_resp_i.gnt & slave_req_o.req; gnt to all other masters = 0.
// - Accept = slave_req_o.req & slave_resp_i.gnt: push sel into FIFO; rr pointer <- sel+1 (mod NMASTER).
// - No accept -> rr pointer unchanged.
// - Response path combinational from FIFO head:
//   - master_resp_o[head].rvalid = slave_resp_i.rvalid; rdata broadcast to all masters.
//   - rvalid=0 to all other masters.
// - slave_resp_i.rvalid pops FIFO; responses in order.
// - Push and pop in the same cycle: count unchanged, both take effect; allowed also when count=1.
// - rvalid with empty FIFO: no master sees rvalid; rsp_err_o set, cleared only by reset.
// - Response for an accepted request may arrive the cycle after gnt at earliest; no same-cycle gnt+rvalid for the same txn.
// - Reset mid-operation: FIFO, lock and counters cleared; in-flight responses after reset set rsp_err_o.
// - NMASTER=1: arbitration degenerates to pass-through; lock and FIFO still operate.
// CONFIGURATION
// - OBI_XBAR_PERF_CNT_EN defined:
//   - perf_gnt_cnt_o[i] increments on each accept from master i.
//   - Counter wraps 2^32-1 -> 0; reset to 0.
// - OBI_XBAR_PERF_CNT_EN undefined: no counter flops; perf_gnt_cnt_o tied to 0.
// TESTING
// - Masters 0,1,2 all req, slave gnt=1 every cycle -> grants 0,1,2,0,1,2; FIFO holds 0,1,2 in order.
// - M1 req, slave gnt=0 for 3 cycles, M0 raises req cycle 2 -> slave_req_o stays M1 addr until gnt.
// - MAX_OUTSTANDING=4, 4 accepts, no rvalid -> 5th req sees slave req=0, outstanding_o=4.
//   - rvalid then frees one slot; grant resumes the following cycle.
// - Accepts M2,M0 then rvalid rdata=0xA5A5_0001 then 0xA5A5_0002 -> M2 then M0 get rvalid with those data.
// - Push+pop same cycle at count=2 -> outstanding_o stays 2; rvalid with FIFO empty -> rsp_err_o=1, no master rvalid.
// - With OBI_XBAR_PERF_CNT_EN: 7 accepts from M1 -> perf_gnt_cnt_o[1]=7, others 0; rst_ni=0 mid-stream clears all.

Source files
------------

// File: rtl/obi_xbar_n_to_one_ot.sv
// N-master to 1-slave OBI arbiter with request locking and a route FIFO for in-order
// responses. Define OBI_XBAR_PERF_CNT_EN to build the per-master accepted-request counters.
package obi_xbar_pkg;
  localparam int unsigned OBI_ADDR_WIDTH = 32;
  localparam int unsigned OBI_DATA_WIDTH = 32;

  typedef struct packed {
    logic                        req;
    logic                        we;
    logic [OBI_DATA_WIDTH/8-1:0] be;
    logic [OBI_ADDR_WIDTH-1:0]   addr;
    logic [OBI_DATA_WIDTH-1:0]   wdata;
  } obi_req_t;

  typedef struct packed {
    logic                      gnt;
    logic                      rvalid;
    logic [OBI_DATA_WIDTH-1:0] rdata;
  } obi_resp_t;
endpackage

module obi_xbar_n_to_one_ot #(
  parameter int unsigned NMASTER         = 3,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter type         obi_req_t       = obi_xbar_pkg::obi_req_t,
  parameter type         obi_resp_t      = obi_xbar_pkg::obi_resp_t
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  obi_req_t  [NMASTER-1:0]              master_req_i,
  output obi_resp_t [NMASTER-1:0]              master_resp_o,
  output obi_req_t                             slave_req_o,
  input  obi_resp_t                            slave_resp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 rsp_err_o,
  output logic [NMASTER-1:0][31:0]             perf_gnt_cnt_o
);

  localparam int unsigned IDX_W = (NMASTER > 1) ? $clog2(NMASTER) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PTR_W-1:0] ptr_t;

  if ($bits(obi_req_t) != 2 + ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH/8) begin : g_req_width_chk
    $error("obi_req_t does not match ADDR_WIDTH/DATA_WIDTH");
  end

  idx_t             rr_q, sel_q, arb_sel, sel, head;
  logic             lock_q, rsp_err_q;
  ptr_t             wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, empty, accept, pop;
  idx_t             route_mem [MAX_OUTSTANDING];

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MAX_OUTSTANDING - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Round-robin search: walking candidates from the far end down to rr_q leaves the
  // first requester at or after the pointer as the winner.
  always_comb begin
    int unsigned cand;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    arb_sel = rr_q;
    cand    = 0;
    for (int k = NMASTER - 1; k >= 0; k--) begin
      cand = int'(rr_q) + k;
      if (cand >= NMASTER) cand = cand - NMASTER;
      if (master_req_i[cand].req) arb_sel = idx_t'(cand);
    end
  end

  assign sel    = lock_q ? sel_q : arb_sel;
  assign full   = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty  = (count_q == '0);
  assign accept = slave_req_o.req & slave_resp_i.gnt;
  assign pop    = slave_resp_i.rvalid & ~empty;
  assign head   = route_mem[rd_ptr_q];

  // Full blocks the request outright; a pop in the same cycle does not open a slot early.
  always_comb begin
    slave_req_o     = master_req_i[sel];
    slave_req_o.req = master_req_i[sel].req & ~full;
  end

  always_comb begin
    for (int i = 0; i < NMASTER; i++) begin
      master_resp_o[i]        = '0;
      master_resp_o[i].gnt    = accept & (sel == idx_t'(i));
      master_resp_o[i].rvalid = pop & (head == idx_t'(i));
      master_resp_o[i].rdata  = slave_resp_i.rdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      sel_q     <= '0;
      lock_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        rr_q   <= (sel == idx_t'(NMASTER - 1)) ? '0 : sel + idx_t'(1);
        lock_q <= 1'b0;
      end else if (slave_req_o.req) begin
        // Hold the stalled master until the slave grants it.
        lock_q <= 1'b1;
        sel_q  <= sel;
      end
      if (accept) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)    rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(accept) - CNT_W'(pop);
      if (slave_resp_i.rvalid && empty) rsp_err_q <= 1'b1;
    end
  end

  // NOTE: route storage has no reset; an entry is only read while count_q says it is valid.
  always_ff @(posedge clk_i) begin
    if (accept) route_mem[wr_ptr_q] <= sel;
  end

  assign outstanding_o = count_q;
  assign rsp_err_o     = rsp_err_q;

`ifdef OBI_XBAR_PERF_CNT_EN
  logic [NMASTER-1:0][31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)     perf_q      <= '0;
    else if (accept) perf_q[sel] <= perf_q[sel] + 32'd1;
  end

  assign perf_gnt_cnt_o = perf_q;
`else
  assign perf_gnt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_obi_xbar_n_to_one_ot.sv
// Self-checking bench for obi_xbar_n_to_one_ot: directed scenarios plus a randomized run
// against a queue-based model of arbitration, locking and in-order response routing.
module tb_obi_xbar_n_to_one_ot;
  import obi_xbar_pkg::*;

  localparam int NM = 3;
  localparam int MO = 4;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  obi_req_t  [NM-1:0]  m_req;
  obi_resp_t [NM-1:0]  m_resp;
  obi_req_t            s_req;
  obi_resp_t           s_resp;
  logic [2:0]          outstanding;
  logic                rsp_err;
  logic [NM-1:0][31:0] perf;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: route queue of master indices, round-robin pointer, lock.
  int route_q[$];
  int rr_m;
  bit lock_m;
  int lock_idx;
  int cnt_m[NM];

  obi_xbar_n_to_one_ot #(
    .NMASTER(NM), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .master_req_i(m_req), .master_resp_o(m_resp),
    .slave_req_o(s_req), .slave_resp_i(s_resp), .outstanding_o(outstanding),
    .rsp_err_o(rsp_err), .perf_gnt_cnt_o(perf)
  );

  always #5 clk = ~clk;

  function automatic logic [NM-1:0] gnt_vec();
    logic [NM-1:0] v;
    for (int i = 0; i < NM; i++) v[i] = m_resp[i].gnt;
    return v;
  endfunction

  function automatic logic [NM-1:0] rvalid_vec();
    logic [NM-1:0] v;
    for (int i = 0; i < NM; i++) v[i] = m_resp[i].rvalid;
    return v;
  endfunction

  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_req  = '0;
    s_resp = '0;
  endtask

  task automatic set_m(input int i, input logic req);
    m_req[i].req   = req;
    m_req[i].we    = 1'b0;
    m_req[i].be    = 4'hF;
    m_req[i].addr  = addr_of(i);
    m_req[i].wdata = ~addr_of(i);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    vectors++; if (perf !== '0) begin miscompares++; $display("FAIL reset_perf: got %h expected 0", perf); end
    vectors++; if (s_req.req !== 1'b0) begin miscompares++; $display("FAIL reset_slave_req: got %b expected 0", s_req.req); end
    vectors++; if (gnt_vec() !== '0 || rvalid_vec() !== '0) begin miscompares++; $display("FAIL reset_master_resp: gnt %b rvalid %b expected 000", gnt_vec(), rvalid_vec()); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [NM-1:0] exp_g, exp_rv;
    logic [31:0]   rd;
    idle();
    for (int i = 0; i < NM; i++) set_m(i, 1'b1);
    s_resp.gnt = 1'b1;
    for (int c = 0; c < 6; c++) begin
      rd = $urandom;
      s_resp.rvalid = (c > 0);
      s_resp.rdata  = rd;
      @(negedge clk);
      exp_g  = '0; exp_g[c % 3] = 1'b1;
      exp_rv = '0; if (c > 0) exp_rv[(c - 1) % 3] = 1'b1;
      vectors++; if (gnt_vec() !== exp_g) begin miscompares++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt_vec(), exp_g); end
      vectors++; if (s_req.addr !== addr_of(c % 3)) begin miscompares++; $display("FAIL rr_addr[%0d]: got %h expected %h", c, s_req.addr, addr_of(c % 3)); end
      vectors++; if (rvalid_vec() !== exp_rv) begin miscompares++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", c, rvalid_vec(), exp_rv); end
      vectors++; if (outstanding !== ((c == 0) ? 3'd0 : 3'd1)) begin miscompares++; $display("FAIL rr_outstanding[%0d]: got %0d", c, outstanding); end
      if (c > 0) begin
        vectors++; if (m_resp[(c - 1) % 3].rdata !== rd) begin miscompares++; $display("FAIL rr_rdata[%0d]: got %h expected %h", c, m_resp[(c - 1) % 3].rdata, rd); end
      end
      tick();
    end
    idle();
    s_resp.rvalid = 1'b1;
    @(negedge clk);
    vectors++; if (rvalid_vec() !== 3'b100) begin miscompares++; $display("FAIL rr_drain: got %b expected 100", rvalid_vec()); end
    tick();
    idle();
    @(negedge clk);
    vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL rr_empty: got %0d expected 0", outstanding); end
    tick();
  endtask

  task automatic test_lock();
    logic [NM-1:0] exp_g;
    idle();
    set_m(1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) set_m(0, 1'b1);
      if (c == 4) set_m(1, 1'b0);
      s_resp.gnt = (c >= 3);
      @(negedge clk);
      exp_g = (c == 3) ? 3'b010 : (c == 4) ? 3'b001 : 3'b000;
      vectors++; if (s_req.req !== 1'b1 || s_req.addr !== addr_of((c < 4) ? 1 : 0)) begin miscompares++; $display("FAIL lock_addr[%0d]: req %b addr %h expected %h", c, s_req.req, s_req.addr, addr_of((c < 4) ? 1 : 0)); end
      vectors++; if (gnt_vec() !== exp_g) begin miscompares++; $display("FAIL lock_gnt[%0d]: got %b expected %b", c, gnt_vec(), exp_g); end
      tick();
    end
    idle();
    for (int c = 0; c < 2; c++) begin
      s_resp.rvalid = 1'b1;
      @(negedge clk);
      exp_g = (c == 0) ? 3'b010 : 3'b001;
      vectors++; if (rvalid_vec() !== exp_g) begin miscompares++; $display("FAIL lock_rvalid[%0d]: got %b expected %b", c, rvalid_vec(), exp_g); end
      tick();
    end
    idle();
  endtask

  task automatic test_full();
    idle();
    set_m(2, 1'b1);
    s_resp.gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++; if (gnt_vec() !== 3'b100 || outstanding !== 3'(c)) begin miscompares++; $display("FAIL full_fill[%0d]: gnt %b outstanding %0d", c, gnt_vec(), outstanding); end
      tick();
    end
    @(negedge clk);
    vectors++; if (s_req.req !== 1'b0 || gnt_vec() !== 3'b000 || outstanding !== 3'd4) begin miscompares++; $display("FAIL full_block: req %b gnt %b outstanding %0d expected 0 000 4", s_req.req, gnt_vec(), outstanding); end
    tick();
    s_resp.rvalid = 1'b1;
    @(negedge clk);
    vectors++; if (s_req.req !== 1'b0 || rvalid_vec() !== 3'b100) begin miscompares++; $display("FAIL full_pop_no_bypass: req %b rvalid %b expected 0 100", s_req.req, rvalid_vec()); end
    tick();
    s_resp.rvalid = 1'b0;
    @(negedge clk);
    vectors++; if (s_req.req !== 1'b1 || gnt_vec() !== 3'b100 || outstanding !== 3'd3) begin miscompares++; $display("FAIL full_resume: req %b gnt %b outstanding %0d expected 1 100 3", s_req.req, gnt_vec(), outstanding); end
    tick();
    idle();
    for (int c = 0; c < 4; c++) begin
      s_resp.rvalid = 1'b1;
      @(negedge clk);
      vectors++; if (rvalid_vec() !== 3'b100) begin miscompares++; $display("FAIL full_drain[%0d]: got %b expected 100", c, rvalid_vec()); end
      tick();
    end
    idle();
    @(negedge clk);
    vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL full_empty: got %0d expected 0", outstanding); end
    tick();
  endtask

  task automatic test_route_data();
    idle();
    set_m(2, 1'b1);
    s_resp.gnt = 1'b1;
    @(negedge clk);
    vectors++; if (gnt_vec() !== 3'b100) begin miscompares++; $display("FAIL route_gnt_m2: got %b", gnt_vec()); end
    tick();
    set_m(2, 1'b0);
    set_m(0, 1'b1);
    @(negedge clk);
    vectors++; if (gnt_vec() !== 3'b001) begin miscompares++; $display("FAIL route_gnt_m0: got %b", gnt_vec()); end
    tick();
    idle();
    s_resp.rvalid = 1'b1;
    s_resp.rdata  = 32'hA5A5_0001;
    @(negedge clk);
    vectors++; if (rvalid_vec() !== 3'b100 || m_resp[2].rdata !== 32'hA5A5_0001) begin miscompares++; $display("FAIL route_rsp_m2: rvalid %b rdata %h", rvalid_vec(), m_resp[2].rdata); end
    tick();
    s_resp.rdata = 32'hA5A5_0002;
    @(negedge clk);
    vectors++; if (rvalid_vec() !== 3'b001 || m_resp[0].rdata !== 32'hA5A5_0002) begin miscompares++; $display("FAIL route_rsp_m0: rvalid %b rdata %h", rvalid_vec(), m_resp[0].rdata); end
    tick();
    idle();
  endtask

  task automatic test_push_pop();
    idle();
    set_m(1, 1'b1);
    s_resp.gnt = 1'b1;
    tick();
    tick();
    s_resp.rvalid = 1'b1;
    @(negedge clk);
    vectors++; if (outstanding !== 3'd2 || gnt_vec() !== 3'b010 || rvalid_vec() !== 3'b010) begin miscompares++; $display("FAIL pushpop_cycle: outstanding %0d gnt %b rvalid %b", outstanding, gnt_vec(), rvalid_vec()); end
    tick();
    idle();
    @(negedge clk);
    vectors++; if (outstanding !== 3'd2) begin miscompares++; $display("FAIL pushpop_count: got %0d expected 2", outstanding); end
    s_resp.rvalid = 1'b1;
    tick();
    tick();
    @(negedge clk);
    vectors++; if (outstanding !== 3'd0 || rvalid_vec() !== 3'b000 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL empty_rvalid: outstanding %0d rvalid %b err %b expected 0 000 0", outstanding, rvalid_vec(), rsp_err); end
    tick();
    idle();
    @(negedge clk);
    vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("FAIL rsp_err_set: got %b expected 1", rsp_err); end
    tick();
    tick();
    @(negedge clk);
    vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("FAIL rsp_err_sticky: got %b expected 1", rsp_err); end
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    @(negedge clk);
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL rsp_err_clear: got %b expected 0", rsp_err); end
    tick();
    set_m(0, 1'b1);
    s_resp.gnt = 1'b1;
    tick();
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL midreset_count: got %0d expected 0", outstanding); end
    tick();
    s_resp.rvalid = 1'b1;
    @(negedge clk);
    vectors++; if (rvalid_vec() !== 3'b000) begin miscompares++; $display("FAIL midreset_rvalid: got %b expected 000", rvalid_vec()); end
    tick();
    idle();
    @(negedge clk);
    vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("FAIL midreset_err: got %b expected 1", rsp_err); end
    tick();
  endtask

  task automatic test_perf();
    do_reset();
    set_m(1, 1'b1);
    s_resp.gnt = 1'b1;
    for (int c = 0; c < 7; c++) begin
      s_resp.rvalid = (c > 0);
      tick();
    end
    idle();
    s_resp.rvalid = 1'b1;
    tick();
    idle();
    @(negedge clk);
`ifdef OBI_XBAR_PERF_CNT_EN
    vectors++; if (perf[1] !== 32'd7 || perf[0] !== 32'd0 || perf[2] !== 32'd0) begin miscompares++; $display("FAIL perf_count: got %0d %0d %0d expected 0 7 0", perf[0], perf[1], perf[2]); end
    tick();
    set_m(1, 1'b1);
    s_resp.gnt = 1'b1;
    tick();
    @(negedge clk);
    vectors++; if (perf[1] !== 32'd8) begin miscompares++; $display("FAIL perf_count8: got %0d expected 8", perf[1]); end
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (perf !== '0 || outstanding !== 3'd0) begin miscompares++; $display("FAIL perf_reset: perf %h outstanding %0d expected 0", perf, outstanding); end
`else
    vectors++; if (perf !== '0) begin miscompares++; $display("FAIL perf_tied: got %h expected 0", perf); end
`endif
    tick();
  endtask

  task automatic test_random();
    logic [NM-1:0] exp_g, exp_rv;
    obi_req_t      exp_s;
    int            sel;
    bit            exp_req;
    int            probe;
    do_reset();
    route_q.delete();
    rr_m   = 0;
    lock_m = 1'b0;
    lock_idx = 0;
    for (int i = 0; i < NM; i++) cnt_m[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NM; i++) begin
        if (!m_req[i].req && $urandom_range(0, 1) == 1) begin
          m_req[i].req   = 1'b1;
          m_req[i].we    = 1'($urandom);
          m_req[i].be    = 4'($urandom);
          m_req[i].addr  = $urandom;
          m_req[i].wdata = $urandom;
        end
      end
      s_resp.gnt    = ($urandom_range(0, 3) != 0);
      s_resp.rvalid = (route_q.size() > 0) && ($urandom_range(0, 1) == 1);
      s_resp.rdata  = $urandom;
      @(negedge clk);
      if (lock_m) sel = lock_idx;
      else begin
        sel = -1;
        for (int k = 0; k < NM; k++)
          if (sel < 0 && m_req[(rr_m + k) % NM].req) sel = (rr_m + k) % NM;
        if (sel < 0) sel = rr_m;
      end
      exp_req = m_req[sel].req && (route_q.size() < MO);
      exp_g   = '0;
      if (exp_req && s_resp.gnt) exp_g[sel] = 1'b1;
      exp_rv  = '0;
      if (s_resp.rvalid) exp_rv[route_q[0]] = 1'b1;
      exp_s     = m_req[sel];
      exp_s.req = exp_req;
      probe     = $urandom_range(0, NM - 1);
      vectors++; if (s_req.req !== exp_req) begin miscompares++; $display("FAIL rand_req[%0d]: got %b expected %b", c, s_req.req, exp_req); end
      if (exp_req) begin
        vectors++; if (s_req !== exp_s) begin miscompares++; $display("FAIL rand_fields[%0d]: got addr %h expected addr %h (master %0d)", c, s_req.addr, exp_s.addr, sel); end
      end
      vectors++; if (gnt_vec() !== exp_g) begin miscompares++; $display("FAIL rand_gnt[%0d]: got %b expected %b", c, gnt_vec(), exp_g); end
      vectors++; if (rvalid_vec() !== exp_rv) begin miscompares++; $display("FAIL rand_rvalid[%0d]: got %b expected %b", c, rvalid_vec(), exp_rv); end
      vectors++; if (m_resp[probe].rdata !== s_resp.rdata) begin miscompares++; $display("FAIL rand_rdata[%0d]: got %h expected %h", c, m_resp[probe].rdata, s_resp.rdata); end
      vectors++; if (outstanding !== 3'(route_q.size()) || rsp_err !== 1'b0) begin miscompares++; $display("FAIL rand_state[%0d]: outstanding %0d err %b expected %0d 0", c, outstanding, rsp_err, route_q.size()); end
      if (s_resp.rvalid) void'(route_q.pop_front());
      if (exp_req && s_resp.gnt) begin
        route_q.push_back(sel);
        rr_m = (sel + 1) % NM;
        lock_m = 1'b0;
        cnt_m[sel]++;
      end else if (exp_req) begin
        lock_m   = 1'b1;
        lock_idx = sel;
      end
      tick();
      for (int i = 0; i < NM; i++) if (exp_g[i]) m_req[i].req = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < NM; i++) begin
`ifdef OBI_XBAR_PERF_CNT_EN
      vectors++; if (perf[i] !== 32'(cnt_m[i])) begin miscompares++; $display("FAIL rand_perf[%0d]: got %0d expected %0d", i, perf[i], cnt_m[i]); end
`else
      vectors++; if (perf[i] !== 32'd0) begin miscompares++; $display("FAIL rand_perf[%0d]: got %0d expected 0", i, perf[i]); end
`endif
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_route_data();
    test_push_pop();
    test_reset_midflight();
    test_perf();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
